// File: rtl/csr_seq_pkg.sv
// Shared types and CSR address map for the CSR/system-instruction serializer.
// csr_index() packs the implemented machine-mode CSRs into a dense select.
package csr_seq_pkg;

    localparam int CSR_BITS  = 3;
    localparam int CSR_IDX_W = CSR_BITS + 1;

    localparam logic [CSR_IDX_W-1:0] CSR_IDX_NONE = '1;

    localparam logic [7:0] CAUSE_ILLEGAL = 8'd2;
    localparam logic [7:0] CAUSE_ECALL_M = 8'd11;

    typedef enum logic [2:0] {
        OP_CSRRW = 3'd0,
        OP_CSRRS = 3'd1,
        OP_CSRRC = 3'd2,
        OP_ECALL = 3'd3,
        OP_MRET  = 3'd4
    } csr_op_t;

    typedef enum logic [1:0] {
        SPECIAL_NONE  = 2'd0,
        SPECIAL_ECALL = 2'd1,
        SPECIAL_MRET  = 2'd2
    } csr_special_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HEAD = 2'd1,
        ST_EXEC      = 2'd2,
        ST_FLUSH     = 2'd3
    } csr_seq_state_t;

    function automatic logic [CSR_IDX_W-1:0] csr_index(input logic [11:0] addr);
        case (addr)
            12'h300: return CSR_IDX_W'(0);  // mstatus
            12'h301: return CSR_IDX_W'(1);  // misa
            12'h304: return CSR_IDX_W'(2);  // mie
            12'h305: return CSR_IDX_W'(3);  // mtvec
            12'h340: return CSR_IDX_W'(4);  // mscratch
            12'h341: return CSR_IDX_W'(5);  // mepc
            12'h342: return CSR_IDX_W'(6);  // mcause
            12'h343: return CSR_IDX_W'(7);  // mtval
            12'h344: return CSR_IDX_W'(8);  // mip
            default: return CSR_IDX_NONE;
        endcase
    endfunction

    function automatic logic csr_valid_addr(input logic [11:0] addr);
        return csr_index(addr) != CSR_IDX_NONE;
    endfunction

endpackage

// File: rtl/csr_seq_rmw_alu.sv
// Read-modify-write datapath for CSRRW/CSRRS/CSRRC.
// Set/clear with a zero source performs no write.
module csr_rmw_alu
    import csr_seq_pkg::*;
(
    input  csr_op_t     op,
    input  logic [31:0] rdata,
    input  logic [31:0] src,
    output logic [31:0] wdata,
    output logic        write_en
);

    always_comb begin
        wdata    = '0;
        write_en = 1'b0;
        case (op)
            OP_CSRRW: begin
                wdata    = src;
                write_en = 1'b1;
            end
            OP_CSRRS: begin
                wdata    = rdata | src;
                write_en = (src != 32'd0);
            end
            OP_CSRRC: begin
                wdata    = rdata & ~src;
                write_en = (src != 32'd0);
            end
            default: begin
                wdata    = '0;
                write_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_seq.sv
// Serializing controller for CSR/system instructions: waits for ROB head,
// performs the CSR access or privilege change, then flushes and redirects.
module csr_seq
    import csr_seq_pkg::*;
#(
    parameter int ROB_TAG_W = 5,
    parameter int CSR_IDX_W = csr_seq_pkg::CSR_IDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  csr_op_t              req_op,
    input  logic [11:0]          req_addr,
    input  logic [31:0]          req_src,
    input  logic [ROB_TAG_W-1:0] req_tag,
    input  logic [31:0]          req_pc,
    input  logic                 rob_head_valid,
    input  logic [ROB_TAG_W-1:0] rob_head_tag,
    input  logic                 exc_valid,
    input  logic [7:0]           exc_mcause,
    input  logic [31:0]          exc_pc,
    input  logic                 kill,
    output logic [CSR_IDX_W-1:0] csr_read_select,
    output logic [CSR_IDX_W-1:0] csr_write_select,
    output logic                 valid_read,
    output logic                 valid_write,
    output logic [31:0]          csr_wdata,
    output logic [1:0]           special,
    output logic                 exception,
    output logic [7:0]           mcause,
    output logic [31:0]          mepc_wdata,
    input  logic [31:0]          csr_rdata,
    input  logic [31:0]          mepc_rdata,
    input  logic [31:0]          mtvec_rdata,
    input  logic                 illegal_access,
    output logic                 cdb_valid,
    output logic [ROB_TAG_W-1:0] cdb_tag,
    output logic [31:0]          cdb_data,
    output logic                 commit_done,
    output logic                 flush,
    output logic [31:0]          redirect_pc
);

    csr_seq_state_t state, next_state;

    csr_op_t              op_q;
    logic [11:0]          addr_q;
    logic [31:0]          src_q;
    logic [ROB_TAG_W-1:0] tag_q;
    logic [31:0]          pc_q;
    logic [31:0]          target_q;
    logic [31:0]          old_q;
    logic                 cdb_en_q;

    logic                 capture;
    logic                 load_target;
    logic [31:0]          target_d;
    logic                 cdb_en_d;
    logic                 illegal;
    logic [31:0]          alu_wdata;
    logic                 alu_we;
    logic [CSR_IDX_W-1:0] sel;

    csr_rmw_alu u_alu (
        .op       (op_q),
        .rdata    (csr_rdata),
        .src      (src_q),
        .wdata    (alu_wdata),
        .write_en (alu_we)
    );

    assign sel = CSR_IDX_W'(csr_index(addr_q));

    always_comb begin
        case (op_q)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: illegal = !csr_valid_addr(addr_q) || illegal_access;
            OP_ECALL:                     illegal = 1'b0;
            OP_MRET:                      illegal = illegal_access;
            default:                      illegal = 1'b1;
        endcase
    end

    always_comb begin
        next_state       = state;
        req_ready        = 1'b0;
        capture          = 1'b0;
        load_target      = 1'b0;
        target_d         = '0;
        cdb_en_d         = 1'b0;
        csr_read_select  = '0;
        csr_write_select = '0;
        valid_read       = 1'b0;
        valid_write      = 1'b0;
        csr_wdata        = '0;
        special          = SPECIAL_NONE;
        exception        = 1'b0;
        mcause           = '0;
        mepc_wdata       = '0;
        cdb_valid        = 1'b0;
        cdb_tag          = '0;
        cdb_data         = '0;
        commit_done      = 1'b0;
        flush            = 1'b0;
        redirect_pc      = '0;

        case (state)
            ST_IDLE: begin
                // A committing exception wins the cycle; dispatch sees no ready.
                req_ready = !exc_valid;
                if (exc_valid) begin
                    exception   = 1'b1;
                    mcause      = exc_mcause;
                    mepc_wdata  = exc_pc;
                    target_d    = mtvec_rdata;
                    load_target = 1'b1;
                    next_state  = ST_FLUSH;
                end else if (req_valid) begin
                    capture    = 1'b1;
                    next_state = ST_WAIT_HEAD;
                end
            end

            ST_WAIT_HEAD: begin
                if (kill) begin
                    next_state = ST_IDLE;
                end else if (exc_valid) begin
                    exception   = 1'b1;
                    mcause      = exc_mcause;
                    mepc_wdata  = exc_pc;
                    target_d    = mtvec_rdata;
                    load_target = 1'b1;
                    next_state  = ST_FLUSH;
                end else if (rob_head_valid && rob_head_tag == tag_q) begin
                    next_state = ST_EXEC;
                end
            end

            ST_EXEC: begin
                valid_read       = 1'b1;
                csr_read_select  = sel;
                csr_write_select = sel;
                csr_wdata        = alu_wdata;
                load_target      = 1'b1;
                next_state       = ST_FLUSH;
                if (illegal) begin
                    exception  = 1'b1;
                    mcause     = CAUSE_ILLEGAL;
                    mepc_wdata = pc_q;
                    target_d   = mtvec_rdata;
                end else if (op_q == OP_ECALL) begin
                    special    = SPECIAL_ECALL;
                    exception  = 1'b1;
                    mcause     = CAUSE_ECALL_M;
                    mepc_wdata = pc_q;
                    target_d   = mtvec_rdata;
                end else if (op_q == OP_MRET) begin
                    special  = SPECIAL_MRET;
                    target_d = mepc_rdata;
                end else begin
                    valid_write = alu_we;
                    target_d    = pc_q + 32'd4;
                    cdb_en_d    = 1'b1;
                end
            end

            ST_FLUSH: begin
                flush       = 1'b1;
                commit_done = 1'b1;
                redirect_pc = target_q;
                cdb_valid   = cdb_en_q;
                cdb_tag     = cdb_en_q ? tag_q : '0;
                cdb_data    = cdb_en_q ? old_q : '0;
                next_state  = ST_IDLE;
            end

            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cdb_en_q <= 1'b0;
        end else begin
            state <= next_state;
            if (load_target) cdb_en_q <= cdb_en_d;
        end
    end

    // Held operands and results carry no reset; they are only observed under state.
    always_ff @(posedge clk) begin
        if (capture) begin
            op_q   <= req_op;
            addr_q <= req_addr;
            src_q  <= req_src;
            tag_q  <= req_tag;
            pc_q   <= req_pc;
        end
        if (load_target) target_q <= target_d;
        if (state == ST_EXEC) old_q <= csr_rdata;
    end

endmodule

// File: tb/tb_csr_seq.sv
// Scoreboard bench for csr_seq: stimulus pushes expected responses computed
// from instruction semantics; a negedge monitor pops and compares them.
module tb_csr_seq;
    import csr_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    csr_op_t     req_op;
    logic [11:0] req_addr;
    logic [31:0] req_src;
    logic [4:0]  req_tag;
    logic [31:0] req_pc;
    logic        rob_head_valid;
    logic [4:0]  rob_head_tag;
    logic        exc_valid;
    logic [7:0]  exc_mcause;
    logic [31:0] exc_pc;
    logic        kill;
    logic [3:0]  csr_read_select, csr_write_select;
    logic        valid_read, valid_write;
    logic [31:0] csr_wdata;
    logic [1:0]  special;
    logic        exception;
    logic [7:0]  mcause;
    logic [31:0] mepc_wdata;
    logic [31:0] csr_rdata, mepc_rdata, mtvec_rdata;
    logic        illegal_access;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        commit_done, flush;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    csr_seq #(.ROB_TAG_W(5), .CSR_IDX_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_src(req_src), .req_tag(req_tag), .req_pc(req_pc),
        .rob_head_valid(rob_head_valid), .rob_head_tag(rob_head_tag),
        .exc_valid(exc_valid), .exc_mcause(exc_mcause), .exc_pc(exc_pc), .kill(kill),
        .csr_read_select(csr_read_select), .csr_write_select(csr_write_select),
        .valid_read(valid_read), .valid_write(valid_write), .csr_wdata(csr_wdata),
        .special(special), .exception(exception), .mcause(mcause), .mepc_wdata(mepc_wdata),
        .csr_rdata(csr_rdata), .mepc_rdata(mepc_rdata), .mtvec_rdata(mtvec_rdata),
        .illegal_access(illegal_access),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .commit_done(commit_done), .flush(flush), .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic        exc;
        logic        chk_cause;
        logic [7:0]  cause;
        logic [31:0] mepc;
        logic [1:0]  spec;
        logic        vwrite;
        logic [31:0] wdata;
        logic        chk_sel;
        logic [3:0]  sel;
        logic [31:0] redirect;
        logic        cdb_v;
        logic [4:0]  tag;
        logic [31:0] data;
    } exp_t;

    localparam logic [11:0] MAP_ADDR [9] = '{12'h300, 12'h301, 12'h304, 12'h305,
                                             12'h340, 12'h341, 12'h342, 12'h343, 12'h344};

    exp_t exp_q[$];
    exp_t cur;
    bit   have_cur = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t trap_exp(logic [7:0] cause, logic [31:0] pc, logic [31:0] mtvec);
        exp_t e = '{default: '0};
        e.exc = 1; e.chk_cause = 1; e.cause = cause; e.mepc = pc; e.redirect = mtvec;
        return e;
    endfunction

    // Reference semantics of one serialized instruction, independent of pipeline timing.
    function automatic exp_t model_op(csr_op_t op, logic [11:0] addr, logic [31:0] src,
                                      logic [4:0] tag, logic [31:0] pc, logic [31:0] rdata,
                                      logic ill, logic [31:0] mtvec, logic [31:0] mepc);
        exp_t e = '{default: '0};
        int idx = -1;
        for (int i = 0; i < 9; i++) if (MAP_ADDR[i] == addr) idx = i;
        if (op == OP_ECALL) begin
            e.exc = 1; e.spec = 2'd1; e.mepc = pc; e.redirect = mtvec;
        end else if (op == OP_MRET && !ill) begin
            e.spec = 2'd2; e.redirect = mepc;
        end else if (op == OP_MRET || idx < 0 || ill) begin
            e = trap_exp(8'd2, pc, mtvec);
        end else begin
            if (op == OP_CSRRW)      e.wdata = src;
            else if (op == OP_CSRRS) e.wdata = rdata | src;
            else                     e.wdata = rdata & ~src;
            e.vwrite   = (op == OP_CSRRW) || (src != 0);
            e.chk_sel  = 1;
            e.sel      = 4'(idx);
            e.redirect = pc + 32'd4;
            e.cdb_v    = 1;
            e.tag      = tag;
            e.data     = rdata;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (exception || valid_read || valid_write || special != 2'd0) begin
                if (have_cur || exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1;
                    chk("exception", exception, cur.exc);
                    chk("special", special, cur.spec);
                    if (cur.exc && cur.chk_cause) chk("mcause", mcause, cur.cause);
                    if (cur.exc) chk("mepc_wdata", mepc_wdata, cur.mepc);
                    chk("valid_write", valid_write, cur.vwrite);
                    if (cur.vwrite) chk("csr_wdata", csr_wdata, cur.wdata);
                    if (cur.chk_sel) begin
                        chk("valid_read", valid_read, 1);
                        chk("read_select", csr_read_select, cur.sel);
                        if (cur.vwrite) chk("write_select", csr_write_select, cur.sel);
                    end
                end
            end
            if (flush) begin
                if (!have_cur) begin
                    chk("flush_without_op", 1, 0);
                end else begin
                    chk("redirect_pc", redirect_pc, cur.redirect);
                    chk("commit_done", commit_done, 1);
                    chk("cdb_valid", cdb_valid, cur.cdb_v);
                    if (cur.cdb_v) begin
                        chk("cdb_tag", cdb_tag, cur.tag);
                        chk("cdb_data", cdb_data, cur.data);
                    end
                    chk("ready_in_flush", req_ready, 0);
                    have_cur = 0;
                end
            end else if (cdb_valid || commit_done) begin
                chk("stray_commit", 1, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_head(input logic [4:0] tag);
        rob_head_valid = 1'($urandom);
        rob_head_tag   = tag + 5'(1 + $urandom_range(0, 30));
    endtask

    // mode 0: executes at head; 1: killed while waiting; 2: exception arrives while waiting
    task automatic do_req(input csr_op_t op, input logic [11:0] addr, input logic [31:0] src,
                          input logic [4:0] tag, input logic [31:0] pc, input logic [31:0] rdata,
                          input logic ill, input int delay, input int mode);
        logic [31:0] mt = $urandom & ~32'h3;
        logic [31:0] me = $urandom & ~32'h3;
        logic [7:0]  ec = 8'($urandom_range(0, 15));
        logic [31:0] ep = $urandom;
        mtvec_rdata = mt; mepc_rdata = me; csr_rdata = rdata; illegal_access = ill;
        req_op = op; req_addr = addr; req_src = src; req_tag = tag; req_pc = pc;
        req_valid = 1;
        chk("req_ready_idle", req_ready, 1);
        step();
        req_valid = 0;
        req_op = OP_CSRRW; req_addr = 12'h0; req_src = 32'h0; req_tag = 5'h0; req_pc = 32'h0;
        for (int i = 0; i < delay; i++) begin
            idle_head(tag);
            step();
        end
        if (mode == 1) begin
            rob_head_valid = 0;
            kill = 1;
            step();
            kill = 0;
            chk("ready_after_kill", req_ready, 1);
            rob_head_valid = 1; rob_head_tag = tag;
            step();
            step();
            rob_head_valid = 0;
        end else if (mode == 2) begin
            exp_q.push_back(trap_exp(ec, ep, mt));
            exc_valid = 1; exc_mcause = ec; exc_pc = ep;
            rob_head_valid = 1; rob_head_tag = tag;
            step();
            exc_valid = 0; rob_head_valid = 0;
            step();
        end else begin
            exp_q.push_back(model_op(op, addr, src, tag, pc, rdata, ill, mt, me));
            rob_head_valid = 1; rob_head_tag = tag;
            step();
            rob_head_valid = 0;
            kill = 1'($urandom);
            step();
            kill = 1'($urandom);
            step();
            kill = 0;
        end
    endtask

    task automatic idle_trap(input logic [7:0] cause, input logic [31:0] pc, input logic with_req);
        logic [31:0] mt = $urandom & ~32'h3;
        logic [4:0]  tag = 5'($urandom);
        mtvec_rdata = mt;
        exp_q.push_back(trap_exp(cause, pc, mt));
        exc_valid = 1; exc_mcause = cause; exc_pc = pc;
        req_valid = with_req; req_op = OP_CSRRW; req_addr = 12'h340; req_tag = tag;
        req_src = 32'h1; req_pc = 32'h400;
        step();
        exc_valid = 0; req_valid = 0;
        step();
        chk("ready_after_trap", req_ready, 1);
        rob_head_valid = 1; rob_head_tag = tag;
        step();
        step();
        rob_head_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; req_valid = 0; req_op = OP_CSRRW; req_addr = 0; req_src = 0; req_tag = 0;
        req_pc = 0; rob_head_valid = 0; rob_head_tag = 0; exc_valid = 0; exc_mcause = 0;
        exc_pc = 0; kill = 0; csr_rdata = 0; mepc_rdata = 0; mtvec_rdata = 0; illegal_access = 0;
        repeat (3) step();
        chk("reset_req_ready", req_ready, 1);
        chk("reset_flush", flush, 0);
        chk("reset_exception", exception, 0);
        chk("reset_valid_write", valid_write, 0);
        chk("reset_cdb_valid", cdb_valid, 0);
        chk("reset_redirect", redirect_pc, 0);
        reset = 0;
        step();

        do_req(OP_CSRRW, 12'h305, 32'h8000_0100, 5'd3, 32'h0000_0200, 32'h0000_1234, 0, 4, 0);
        do_req(OP_CSRRS, 12'h305, 32'h0, 5'd7, 32'h0000_0300, 32'h0000_0800, 0, 1, 0);
        do_req(OP_CSRRW, 12'h340, 32'hDEAD_BEEF, 5'd9, 32'h0000_0404, 32'h5555_0000, 1, 2, 0);
        do_req(OP_ECALL, 12'h000, 32'h0, 5'd11, 32'h0000_0100, 32'h0, 0, 0, 0);
        do_req(OP_CSRRC, 12'h341, 32'h0, 5'd5, 32'h0000_0500, 32'h1, 0, 2, 1);
        do_req(OP_CSRRC, 12'h300, 32'h0000_00F0, 5'd12, 32'h0000_0600, 32'h0000_0FFF, 0, 0, 0);
        idle_trap(8'd4, 32'h0000_0700, 1);
        do_req(OP_MRET, 12'h000, 32'h0, 5'd13, 32'h0000_0800, 32'h0, 0, 3, 0);
        do_req(OP_MRET, 12'h000, 32'h0, 5'd14, 32'h0000_0804, 32'h0, 1, 1, 0);
        do_req(OP_CSRRS, 12'hC00, 32'h1, 5'd15, 32'hFFFF_FFFC, 32'h0, 0, 1, 0);
        do_req(OP_CSRRW, 12'h344, 32'h3, 5'd16, 32'hFFFF_FFFC, 32'h7, 0, 0, 0);
        do_req(OP_CSRRS, 12'h342, 32'h1, 5'd17, 32'h0000_0900, 32'h2, 0, 2, 2);

        for (int n = 0; n < 200; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 10) begin
                idle_trap(8'($urandom_range(0, 15)), $urandom, 1'($urandom));
            end else begin
                csr_op_t     op   = csr_op_t'($urandom_range(0, 4));
                logic [11:0] addr = ($urandom_range(0, 9) < 8) ? MAP_ADDR[$urandom_range(0, 8)]
                                                               : 12'hC00 + 12'($urandom_range(0, 255));
                logic [31:0] src  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                int          mode = (r < 75) ? 0 : ((r < 88) ? 1 : 2);
                do_req(op, addr, src, 5'($urandom), $urandom, $urandom,
                       1'($urandom_range(0, 4) == 0), $urandom_range(0, 5), mode);
            end
        end

        repeat (3) step();
        chk("queue_drained", exp_q.size(), 0);
        chk("no_pending_flush", have_cur, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
